// File: rtl/otter_cu_fsm_mc_if.sv
// otter_cu_fsm_mc_if: IR fields, handshakes and enables between the OTTER control FSM and its datapath.
interface otter_cu_fsm_mc_if;
    logic [6:0] IR_OPCODE;
    logic [2:0] IR_FUNCT;
    logic       IR_25;
    logic       MD_DONE;
    logic       INTR;
    logic       MIE;
    logic       PC_WE;
    logic       RF_WE;
    logic       MEM_RDEN1;
    logic       MEM_RDEN2;
    logic       MEM_WE2;
    logic       CSR_WE;
    logic       MD_START;
    logic       MRET_EXEC;
    logic       INT_TAKEN;
    logic       ILLEGAL;
    logic [2:0] DBG_STATE;
    modport master (
        input  IR_OPCODE, IR_FUNCT, IR_25, MD_DONE, INTR, MIE,
        output PC_WE, RF_WE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, CSR_WE,
               MD_START, MRET_EXEC, INT_TAKEN, ILLEGAL, DBG_STATE
    );
    modport slave (
        output IR_OPCODE, IR_FUNCT, IR_25, MD_DONE, INTR, MIE,
        input  PC_WE, RF_WE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, CSR_WE,
               MD_START, MRET_EXEC, INT_TAKEN, ILLEGAL, DBG_STATE
    );
endinterface

// File: rtl/otter_cu_fsm_mc.sv
// otter_cu_fsm_mc: multicycle OTTER control FSM with memory-latency counting and mul/div wait.
// Define CU_INTR_EN to take interrupts at instruction completion.
module otter_cu_fsm_mc #(
    parameter int MEM_LAT = 1,
    parameter int MD_EN   = 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    otter_cu_fsm_mc_if.master  bus
);
    typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, WB = 3'd2, MD_WAIT = 3'd3, INTRPT = 3'd4} state_t;
    localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

    state_t     state, next_state;
    logic [3:0] cnt, cnt_next;
    logic       pc, rf, rd1, rd2, we2, csr, mds, mret, int_t, ill, done, no_int, take_int, last;

`ifdef CU_INTR_EN
    assign take_int = bus.INTR & bus.MIE;
`else
    logic unused_intr;
    assign take_int = 1'b0;
    assign unused_intr = bus.INTR ^ bus.MIE;
`endif

    assign last = (cnt == LAST);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= FETCH;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        {pc, rf, rd1, rd2, we2, csr, mds, mret, int_t, ill, done, no_int} = '0;
        case (state)
            FETCH: begin
                rd1        = 1'b1;
                cnt_next   = last ? 4'd0 : cnt + 4'd1;
                next_state = last ? DECODE : FETCH;
            end
            DECODE: case (bus.IR_OPCODE)
                7'b0000011: begin
                    rd2        = 1'b1;
                    next_state = WB;
                end
                7'b0100011: {we2, pc, done} = 3'b111;
                7'b1100011: {pc, done} = 2'b11;
                7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111:
                    if (bus.IR_OPCODE == 7'b0110011 && bus.IR_25 && MD_EN != 0) begin
                        mds        = 1'b1;
                        next_state = MD_WAIT;
                    end else begin
                        {rf, pc, done} = 3'b111;
                    end
                7'b1110011: begin
                    {pc, done} = 2'b11;
                    csr        = bus.IR_FUNCT != 3'b000;
                    rf         = bus.IR_FUNCT != 3'b000;
                    mret       = bus.IR_FUNCT == 3'b000;
                    no_int     = bus.IR_FUNCT == 3'b000;
                end
                default: {ill, pc, done, no_int} = 4'b1111;
            endcase
            WB: begin
                cnt_next       = last ? 4'd0 : cnt + 4'd1;
                {rf, pc, done} = {3{last}};
            end
            MD_WAIT: {rf, pc, done} = {3{bus.MD_DONE}};
            INTRPT: begin
                {int_t, pc} = 2'b11;
                next_state  = FETCH;
            end
            default: next_state = FETCH;
        endcase
        if (done) next_state = (take_int && !no_int) ? INTRPT : FETCH;
    end

    // Reset gates every output so nothing fires while the FSM is being forced back to FETCH.
    assign bus.PC_WE     = RST_N & pc;
    assign bus.RF_WE     = RST_N & rf;
    assign bus.MEM_RDEN1 = RST_N & rd1;
    assign bus.MEM_RDEN2 = RST_N & rd2;
    assign bus.MEM_WE2   = RST_N & we2;
    assign bus.CSR_WE    = RST_N & csr;
    assign bus.MD_START  = RST_N & mds;
    assign bus.MRET_EXEC = RST_N & mret;
    assign bus.INT_TAKEN = RST_N & int_t;
    assign bus.ILLEGAL   = RST_N & ill;
    assign bus.DBG_STATE = {3{RST_N}} & state;
endmodule

// File: tb/tb_otter_cu_fsm_mc.sv
// tb_otter_cu_fsm_mc: directed vectors on a MEM_LAT=1/MD_EN=1 and a MEM_LAT=3/MD_EN=0 instance driven in lockstep.
module tb_otter_cu_fsm_mc;
    localparam logic [12:0] PC = 13'h1000, RF = 13'h0800, RD1 = 13'h0400, RD2 = 13'h0200, WE2 = 13'h0100,
                            CSR = 13'h0080, MDS = 13'h0040, MRET = 13'h0020, INT = 13'h0010, ILL = 13'h0008;
    localparam logic [6:0] ADDI = 7'b0010011, LW = 7'b0000011, SW = 7'b0100011, RTYPE = 7'b0110011,
                           SYS = 7'b1110011, BAD = 7'b1111111;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [6:0] opc = ADDI;
    logic [2:0] funct = 3'b000;
    logic       b25 = 1'b0, md_done = 1'b0, intr = 1'b0, mie = 1'b1;
    logic [12:0] o1, o3;
    int checks = 0, errors = 0;

    always #5 CLK = ~CLK;

    otter_cu_fsm_mc_if b1();
    otter_cu_fsm_mc_if b3();
    assign {b1.IR_OPCODE, b1.IR_FUNCT, b1.IR_25, b1.MD_DONE, b1.INTR, b1.MIE} = {opc, funct, b25, md_done, intr, mie};
    assign {b3.IR_OPCODE, b3.IR_FUNCT, b3.IR_25, b3.MD_DONE, b3.INTR, b3.MIE} = {opc, funct, b25, md_done, intr, mie};
    assign o1 = {b1.PC_WE, b1.RF_WE, b1.MEM_RDEN1, b1.MEM_RDEN2, b1.MEM_WE2, b1.CSR_WE, b1.MD_START,
                 b1.MRET_EXEC, b1.INT_TAKEN, b1.ILLEGAL, b1.DBG_STATE};
    assign o3 = {b3.PC_WE, b3.RF_WE, b3.MEM_RDEN1, b3.MEM_RDEN2, b3.MEM_WE2, b3.CSR_WE, b3.MD_START,
                 b3.MRET_EXEC, b3.INT_TAKEN, b3.ILLEGAL, b3.DBG_STATE};

    otter_cu_fsm_mc #(.MEM_LAT(1), .MD_EN(1)) d1 (.CLK(CLK), .RST_N(RST_N), .bus(b1));
    otter_cu_fsm_mc #(.MEM_LAT(3), .MD_EN(0)) d3 (.CLK(CLK), .RST_N(RST_N), .bus(b3));

    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs after the falling edge, then compare both instances' outputs.
    task automatic cyc(input string tag, input logic rst_n, input logic [6:0] op, input logic [2:0] f,
                       input logic m25, input logic done, input logic irq,
                       input logic [12:0] e1, input logic [12:0] e3);
        @(negedge CLK);
        {RST_N, opc, funct, b25, md_done, intr} = {rst_n, op, f, m25, done, irq};
        #1;
        check({tag, "/lat1"}, o1, e1);
        check({tag, "/lat3"}, o3, e3);
    endtask

    task automatic reset();
        cyc("rst", 1'b0, ADDI, 3'b000, 1'b0, 1'b0, 1'b0, 13'h0, 13'h0);
    endtask

    initial begin
        reset();
        cyc("addi0", 1, ADDI, 0, 0, 0, 0, RD1, RD1);
        cyc("addi1", 1, ADDI, 0, 0, 0, 0, PC | RF | 1, RD1);
        cyc("addi2", 1, ADDI, 0, 0, 0, 0, RD1, RD1);
        cyc("addi3", 1, ADDI, 0, 0, 0, 0, PC | RF | 1, PC | RF | 1);

        reset();
        cyc("lw0", 1, LW, 0, 0, 0, 0, RD1, RD1);
        cyc("lw1", 1, LW, 0, 0, 0, 0, RD2 | 1, RD1);
        cyc("lw2", 1, LW, 0, 0, 0, 0, PC | RF | 2, RD1);
        cyc("lw3", 1, LW, 0, 0, 0, 0, RD1, RD2 | 1);
        cyc("lw4", 1, LW, 0, 0, 0, 0, RD2 | 1, 2);
        cyc("lw5", 1, LW, 0, 0, 0, 0, PC | RF | 2, 2);
        cyc("lw6", 1, LW, 0, 0, 0, 0, RD1, PC | RF | 2);
        cyc("lw7", 1, LW, 0, 0, 0, 0, RD2 | 1, RD1);

        reset();
        cyc("mul0", 1, RTYPE, 0, 1, 0, 0, RD1, RD1);
        cyc("mul1", 1, RTYPE, 0, 1, 0, 0, MDS | 1, RD1);
        cyc("mul2", 1, RTYPE, 0, 1, 0, 0, 3, RD1);
        cyc("mul3", 1, RTYPE, 0, 1, 0, 0, 3, PC | RF | 1);
        cyc("mul4", 1, RTYPE, 0, 1, 0, 0, 3, RD1);
        cyc("mul5", 1, RTYPE, 0, 1, 0, 0, 3, RD1);
        cyc("mul6", 1, RTYPE, 0, 1, 1, 0, PC | RF | 3, RD1);
        cyc("mul7", 1, RTYPE, 0, 1, 0, 0, RD1, PC | RF | 1);

        reset();
        cyc("ill0", 1, BAD, 0, 0, 0, 1, RD1, RD1);
        cyc("ill1", 1, BAD, 0, 0, 0, 1, PC | ILL | 1, RD1);
        cyc("ill2", 1, BAD, 0, 0, 0, 1, RD1, RD1);
        cyc("ill3", 1, BAD, 0, 0, 0, 1, PC | ILL | 1, PC | ILL | 1);
        cyc("ill4", 1, BAD, 0, 0, 0, 1, RD1, RD1);

        reset();
        cyc("mdrst0", 1, RTYPE, 0, 1, 0, 0, RD1, RD1);
        cyc("mdrst1", 1, RTYPE, 0, 1, 0, 0, MDS | 1, RD1);
        cyc("mdrst2", 1, RTYPE, 0, 1, 0, 0, 3, RD1);
        cyc("mdrst3", 0, RTYPE, 0, 1, 0, 0, 13'h0, 13'h0);
        cyc("mdrst4", 1, RTYPE, 0, 1, 1, 0, RD1, RD1);
        cyc("mdrst5", 1, RTYPE, 0, 1, 0, 0, MDS | 1, RD1);

        reset();
        cyc("csr0", 1, SYS, 3'b001, 0, 0, 0, RD1, RD1);
        cyc("csr1", 1, SYS, 3'b001, 0, 0, 0, CSR | RF | PC | 1, RD1);
        cyc("mret2", 1, SYS, 3'b000, 0, 0, 1, RD1, RD1);
        cyc("mret3", 1, SYS, 3'b000, 0, 0, 1, MRET | PC | 1, MRET | PC | 1);
        cyc("mret4", 1, SYS, 3'b000, 0, 0, 1, RD1, RD1);

        reset();
        cyc("sw0", 1, SW, 0, 0, 0, 1, RD1, RD1);
        cyc("sw1", 1, SW, 0, 0, 0, 1, WE2 | PC | 1, RD1);
`ifdef CU_INTR_EN
        cyc("sw2", 1, SW, 0, 0, 0, 1, INT | PC | 4, RD1);
        cyc("sw3", 1, SW, 0, 0, 0, 1, RD1, WE2 | PC | 1);
        cyc("sw4", 1, SW, 0, 0, 0, 1, WE2 | PC | 1, INT | PC | 4);
        cyc("sw5", 1, SW, 0, 0, 0, 1, INT | PC | 4, RD1);
`else
        cyc("sw2", 1, SW, 0, 0, 0, 1, RD1, RD1);
        cyc("sw3", 1, SW, 0, 0, 0, 1, WE2 | PC | 1, WE2 | PC | 1);
        cyc("sw4", 1, SW, 0, 0, 0, 1, RD1, RD1);
        cyc("sw5", 1, SW, 0, 0, 0, 1, WE2 | PC | 1, RD1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/otter_cu_fsm_mc.md
Name: otter_cu_fsm_mc

Overview:
Parametrised multicycle control-unit FSM for the OTTER RV32I core. It sequences fetch, decode, load writeback and multiply/divide wait, and generates all write, read and strobe enables. It handles memories with configurable read latency and an M-extension unit with a start/done handshake. It works alongside the combinational decoder, which still supplies the mux selects.

Parameters:
MEM_LAT, 1, memory read latency in cycles (legal 1..15); applies to instruction fetch and load data.
MD_EN, 1, 1 = R-type with IR_25=1 dispatched to the mul/div unit; 0 = treated as a normal R-type.

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  synchronous, active-low reset
IR_OPCODE  in  7  instruction bits [6:0]
IR_FUNCT  in  3  instruction bits [14:12]
IR_25  in  1  instruction bit 25 (M-extension select)
MD_DONE  in  1  mul/div result valid
INTR  in  1  external interrupt request, level
MIE  in  1  global interrupt enable (mstatus.MIE)
PC_WE  out  1  PC write enable
RF_WE  out  1  register file write enable
MEM_RDEN1  out  1  instruction read enable
MEM_RDEN2  out  1  data read enable
MEM_WE2  out  1  data write enable
CSR_WE  out  1  CSR write enable
MD_START  out  1  one-cycle mul/div start pulse
MRET_EXEC  out  1  mret executing
INT_TAKEN  out  1  interrupt entry strobe
ILLEGAL  out  1  illegal-opcode pulse
DBG_STATE  out  3  current state encoding

Behaviour:
- States and encodings: FETCH=0, DECODE=1, WB=2, MD_WAIT=3, INTRPT=4. Internal counter cnt is 4 bits wide.
- Reset: on the CLK edge where RST_N=0, state<=FETCH and cnt<=0. While RST_N=0, every output is forced to 0, DBG_STATE included. Reset in any state, including MD_WAIT or WB, abandons the instruction; no writes occur.
- Outputs are combinational from state, cnt and IR fields. Any output not listed for a state is 0.
- FETCH:
  - MEM_RDEN1=1 for all cycles in this state.
  - cnt increments each cycle. When cnt==MEM_LAT-1: cnt<=0 and go to DECODE. FETCH therefore lasts exactly MEM_LAT cycles.
- DECODE (single cycle; IR is valid). Decoded by opcode:
  - 0000011 load: MEM_RDEN2=1; go to WB.
  - 0100011 store: MEM_WE2=1, PC_WE=1; go to FETCH.
  - 1100011 branch: PC_WE=1; go to FETCH.
  - 0110011 with IR_25=1 and MD_EN=1: MD_START=1; go to MD_WAIT.
  - 0110011 (other cases), 0010011, 0110111, 0010111, 1101111, 1100111: RF_WE=1, PC_WE=1; go to FETCH.
  - 1110011 with IR_FUNCT!=000: CSR_WE=1, RF_WE=1, PC_WE=1; go to FETCH.
  - 1110011 with IR_FUNCT==000: MRET_EXEC=1, PC_WE=1; go to FETCH.
  - Any other opcode: ILLEGAL=1, PC_WE=1, no other writes; go to FETCH.
- WB:
  - cnt increments each cycle. On the cycle where cnt==MEM_LAT-1: RF_WE=1, PC_WE=1, cnt<=0, go to FETCH.
  - MEM_RDEN2 is 0 in WB.
- MD_WAIT:
  - Stays in this state while MD_DONE=0; no timeout.
  - The first cycle with MD_DONE=1 (including the first cycle in the state): RF_WE=1, PC_WE=1; go to FETCH.
  - MD_DONE is ignored in every other state. MD_START is never reasserted while waiting.
- Instruction completion is any transition to FETCH from DECODE, WB or MD_WAIT. Interrupt sampling at completion is defined under Optional Feature.
- INTRPT: INT_TAKEN=1, PC_WE=1 for one cycle; go to FETCH.
- Throughput: a plain ALU instruction takes MEM_LAT+1 cycles; a load takes 2*MEM_LAT+1 cycles.

Optional Feature:
- Macro: CU_INTR_EN.
- Defined: at instruction completion, if INTR&&MIE, the next state is INTRPT instead of FETCH. Writes of the completing instruction still occur that cycle. Interrupts are not taken after an ILLEGAL instruction or after MRET_EXEC; those go to FETCH.
- Undefined: INTR and MIE are ignored, INT_TAKEN is tied to 0, and INTRPT is unreachable.

Test Plan:
- MEM_LAT=1, reset, addi (0010011) → FETCH 1 cycle, DECODE with RF_WE=PC_WE=1; 2-cycle loop; DBG_STATE sequence 0,1,0.
- MEM_LAT=3, lw (0000011) → MEM_RDEN1 high 3 cycles; DECODE MEM_RDEN2=1; WB 3 cycles with RF_WE=PC_WE=1 only on the 3rd; total 7 cycles.
- MD_EN=1, mul (0110011, IR_25=1), MD_DONE raised 5 cycles after MD_START → MD_START exactly 1 cycle; RF_WE=PC_WE=1 on the MD_DONE cycle; no RF_WE before it.
- Opcode 1111111 → ILLEGAL=1, PC_WE=1, RF_WE=MEM_WE2=CSR_WE=0; then FETCH.
- RST_N=0 for one cycle while in MD_WAIT → all outputs 0 during reset; state FETCH next; a subsequent MD_DONE pulse in FETCH produces no RF_WE.
- CU_INTR_EN defined, INTR=MIE=1 during sw (0100011) → MEM_WE2=1 in DECODE, then INTRPT with INT_TAKEN=PC_WE=1, then FETCH. Same stimulus with macro undefined → INT_TAKEN stays 0.
